// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Purpose : Shared types for register-file access masters.
// Contents: rf_status_t -- response status returned with every command.
//   OKAY       : command completed (read data valid / write verified)
//   RETRY_FAIL : write readback never matched after all re-attempts
//   ADDR_ERR   : register index outside the implemented register range
// -----------------------------------------------------------------------------
package reg_file_pkg;

    typedef enum logic [1:0] {
        OKAY       = 2'd0,
        RETRY_FAIL = 2'd1,
        ADDR_ERR   = 2'd2
    } rf_status_t;

endpackage : reg_file_pkg

// File: rtl/ifc_reg_file_direct_access.sv
// -----------------------------------------------------------------------------
// ifc_reg_file_direct_access
// Purpose : Direct per-register access port into a shared register file.
//   write_req  [NUM_REGISTERS]        : one write strobe per register
//   write_data [NUM_REGISTERS][W]     : write data per register
//   read_data  [NUM_REGISTERS][W]     : current contents of every register
// Modports: master drives the write side and samples read_data;
//           slave (the register file) does the opposite.
// -----------------------------------------------------------------------------
interface ifc_reg_file_direct_access #(
    parameter int REGISTER_WIDTH = 32,
    parameter int NUM_REGISTERS  = 16
);

    logic [NUM_REGISTERS-1:0]  write_req;
    logic [REGISTER_WIDTH-1:0] write_data [NUM_REGISTERS];
    logic [REGISTER_WIDTH-1:0] read_data  [NUM_REGISTERS];

    modport master (
        output write_req,
        output write_data,
        input  read_data
    );

    modport slave (
        input  write_req,
        input  write_data,
        output read_data
    );

endinterface : ifc_reg_file_direct_access

// File: rtl/reg_file_access_master.sv
// -----------------------------------------------------------------------------
// reg_file_access_master
// Purpose : Turns single read/write commands into direct register-file
//           accesses. Writes are verified by reading the register back one
//           cycle after the strobe and re-issued (up to MAX_RETRIES times) when
//           another master won the arbitration for that register.
// Ports   :
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid/req_ready      : command handshake
//   req_write, req_addr,
//   req_wdata                : command (1 = write), register index, write data
//   rsp_valid/rsp_ready      : response handshake
//   rsp_rdata, rsp_status    : read data (or write readback), rf_status_t
//   if_reg_file              : master side of the register-file access port
// -----------------------------------------------------------------------------
module reg_file_access_master
    import reg_file_pkg::*;
#(
    parameter int REGISTER_WIDTH = 32,
    parameter int NUM_REGISTERS  = 16,
    parameter int MAX_RETRIES    = 3,
    localparam int ADDR_WIDTH    = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [REGISTER_WIDTH-1:0] req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [REGISTER_WIDTH-1:0] rsp_rdata,
    output rf_status_t                rsp_status,
    ifc_reg_file_direct_access.master if_reg_file
);

    // A zero-retry build still needs a 1-bit counter to keep the logic legal.
    localparam int CNT_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CHECK,
        RESP
    } state_t;

    state_t                    state_q,  state_d;
    logic [ADDR_WIDTH-1:0]     addr_q,   addr_d;
    logic [REGISTER_WIDTH-1:0] wdata_q,  wdata_d;
    logic [CNT_W-1:0]          cnt_q,    cnt_d;
    logic [REGISTER_WIDTH-1:0] rdata_q,  rdata_d;
    rf_status_t                status_q, status_d;

    logic                      addr_ok;
    logic                      retry_left;
    logic [REGISTER_WIDTH-1:0] rd_req;   // read_data at the incoming address
    logic [REGISTER_WIDTH-1:0] rd_cap;   // read_data at the captured address

    // Only non-power-of-two register counts can produce an out-of-range index.
    assign addr_ok    = (32'(req_addr) < NUM_REGISTERS);
    assign retry_left = (32'(cnt_q) < MAX_RETRIES);

    // Mux by compare rather than direct indexing so an illegal address never
    // indexes past the end of read_data.
    always_comb begin
        rd_req = '0;
        rd_cap = '0;
        for (int i = 0; i < NUM_REGISTERS; i++) begin
            if (ADDR_WIDTH'(i) == req_addr) rd_req = if_reg_file.read_data[i];
            if (ADDR_WIDTH'(i) == addr_q)   rd_cap = if_reg_file.read_data[i];
        end
    end

    // Write strobe decoded purely from the state register so that an
    // asynchronous reset removes it immediately.
    always_comb begin
        if_reg_file.write_req = '0;
        for (int i = 0; i < NUM_REGISTERS; i++) begin
            if_reg_file.write_data[i] = wdata_q;
            if ((state_q == WRITE) && (ADDR_WIDTH'(i) == addr_q)) begin
                if_reg_file.write_req[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        status_d = status_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    if (!addr_ok) begin
                        state_d  = RESP;
                        rdata_d  = '0;
                        status_d = ADDR_ERR;
                    end else if (req_write) begin
                        state_d = WRITE;
                    end else begin
                        // Read completes on the sample taken at acceptance.
                        state_d  = RESP;
                        rdata_d  = rd_req;
                        status_d = OKAY;
                    end
                end
            end

            WRITE: begin
                state_d = CHECK;
            end

            CHECK: begin
                rdata_d = rd_cap;
                if (rd_cap == wdata_q) begin
                    state_d  = RESP;
                    status_d = OKAY;
                end else if (retry_left) begin
                    state_d = WRITE;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    state_d  = RESP;
                    status_d = RETRY_FAIL;
                end
            end

            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            status_q <= OKAY;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = rdata_q;
    assign rsp_status = status_q;

endmodule : reg_file_access_master

// File: tb/tb_reg_file_access_master.sv
module tb_reg_file_access_master;
    import reg_file_pkg::*;

    localparam int W    = 32;
    localparam int NREG = 12;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [3:0]      req_addr;
    logic [W-1:0]    req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [W-1:0]    rsp_rdata;
    rf_status_t      rsp_status;

    // master 0: bench-driven competitor (higher priority); master 1: DUT
    ifc_reg_file_direct_access #(.REGISTER_WIDTH(W), .NUM_REGISTERS(NREG)) m0_if ();
    ifc_reg_file_direct_access #(.REGISTER_WIDTH(W), .NUM_REGISTERS(NREG)) m1_if ();

    reg_file_access_master #(
        .REGISTER_WIDTH(W),
        .NUM_REGISTERS (NREG),
        .MAX_RETRIES   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_status (rsp_status),
        .if_reg_file(m1_if)
    );

    // Register file model: lowest master index wins a same-cycle collision.
    logic [W-1:0] regs [NREG];

    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (m0_if.write_req[i])      regs[i] <= m0_if.write_data[i];
            else if (m1_if.write_req[i]) regs[i] <= m1_if.write_data[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            m0_if.read_data[i] = regs[i];
            m1_if.read_data[i] = regs[i];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] rdata;
        logic [1:0]   status;
        int           lat;
        string        tag;
    } exp_t;

    exp_t exp_q[$];

    // Monitor / scoreboard
    int           acc_cyc   = 0;
    int           acc_addr  = 0;
    logic [W-1:0] acc_wdata = '0;
    int           pulses    = 0;
    logic         rsp_seen  = 1'b0;
    logic         hs_prev   = 1'b0;
    logic [W-1:0] hold_rdata;
    logic [1:0]   hold_status;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (req_valid && req_ready) begin
                acc_cyc   = cyc;
                acc_addr  = int'(req_addr);
                acc_wdata = req_wdata;
            end
            if (m1_if.write_req != '0) begin
                pulses++;
                check_eq("wr_onehot", 64'(m1_if.write_req), 64'(12'(1) << acc_addr));
                if (acc_addr < NREG) check_eq("wr_data", 64'(m1_if.write_data[acc_addr]), 64'(acc_wdata));
            end
            if (hs_prev) begin
                check_eq("post_hs_ready", 64'(req_ready), 64'(1));
                check_eq("post_hs_valid", 64'(rsp_valid), 64'(0));
            end
            hs_prev = 1'b0;
            if (rsp_valid) begin
                check_eq("busy_ready", 64'(req_ready), 64'(0));
                if (!rsp_seen) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_rsp", 64'(rsp_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check_eq({e.tag, "_lat"},    64'(cyc - acc_cyc), 64'(e.lat));
                        check_eq({e.tag, "_rdata"},  64'(rsp_rdata),     64'(e.rdata));
                        check_eq({e.tag, "_status"}, 64'(rsp_status),    64'(e.status));
                    end
                    rsp_seen    = 1'b1;
                    hold_rdata  = rsp_rdata;
                    hold_status = rsp_status;
                end else begin
                    check_eq("hold_rdata",  64'(rsp_rdata),  64'(hold_rdata));
                    check_eq("hold_status", 64'(rsp_status), 64'(hold_status));
                end
                if (rsp_ready) begin
                    rsp_seen = 1'b0;
                    hs_prev  = 1'b1;
                end
            end
        end else begin
            rsp_seen = 1'b0;
            hs_prev  = 1'b0;
        end
    end

    // Call right after posedge+#1; returns at posedge+#1 after acceptance.
    task automatic send(input logic wr, input logic [3:0] addr, input logic [W-1:0] data,
                        input logic push, input logic [W-1:0] erd, input logic [1:0] est,
                        input int elat, input string tag);
        exp_t e;
        logic ok;
        if (push) begin
            e.rdata  = erd;
            e.status = est;
            e.lat    = elat;
            e.tag    = tag;
            exp_q.push_back(e);
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq({tag, "_accept_timeout"}, 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Returns at a negedge once every expected response has been consumed.
    task automatic wait_done(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) begin
                ok = 1'b0 | 1'b1;
                break;
            end
        end
        if (!ok) check_eq({tag, "_rsp_timeout"}, 64'(exp_q.size()), 64'(0));
    endtask

    int p0;
    logic found;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        m0_if.write_req = '0;
        for (int k = 0; k < NREG; k++) m0_if.write_data[k] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rsp_valid",  64'(rsp_valid),         64'(0));
        check_eq("rst_rsp_rdata",  64'(rsp_rdata),         64'(0));
        check_eq("rst_rsp_status", 64'(rsp_status),        64'(OKAY));
        check_eq("rst_write_req",  64'(m1_if.write_req),   64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rel_req_ready", 64'(req_ready), 64'(1));

        // Preload reg 5 through master 0
        @(posedge clk);
        #1;
        m0_if.write_req[5]  = 1'b1;
        m0_if.write_data[5] = 32'hA5A5_0001;
        @(posedge clk);
        #1;
        m0_if.write_req = '0;

        // Read
        send(1'b0, 4'd5, '0, 1'b1, 32'hA5A5_0001, OKAY, 1, "read5");
        wait_done("read5");

        // Uncontended write
        p0 = pulses;
        @(posedge clk);
        #1;
        send(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, OKAY, 3, "write3");
        wait_done("write3");
        check_eq("write3_pulses", 64'(pulses - p0), 64'(1));
        check_eq("write3_reg",    64'(regs[3]),     64'(32'hDEAD_BEEF));

        // Arbitration loss: master 0 writes reg 3 = 1 every cycle
        @(posedge clk);
        #1;
        m0_if.write_req[3]  = 1'b1;
        m0_if.write_data[3] = 32'h1;
        p0 = pulses;
        send(1'b1, 4'd3, 32'h0000_0055, 1'b1, 32'h1, RETRY_FAIL, 9, "arb");
        wait_done("arb");
        check_eq("arb_pulses", 64'(pulses - p0), 64'(4));
        @(posedge clk);
        #1;
        m0_if.write_req = '0;

        // Bad address
        p0 = pulses;
        @(posedge clk);
        #1;
        send(1'b1, 4'd13, 32'h1234_5678, 1'b1, 32'h0, ADDR_ERR, 1, "badaddr");
        wait_done("badaddr");
        check_eq("badaddr_pulses", 64'(pulses - p0), 64'(0));

        // Backpressure: response held for 5 cycles
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        send(1'b0, 4'd5, '0, 1'b1, 32'hA5A5_0001, OKAY, 1, "bp");
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("bp_rsp_seen", 64'(found), 64'(1));
        repeat (5) @(negedge clk);
        check_eq("bp_still_valid", 64'(rsp_valid), 64'(1));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_done("bp");

        // Reset during WRITE
        @(posedge clk);
        #1;
        send(1'b1, 4'd7, 32'hCAFE_0007, 1'b0, '0, OKAY, 0, "rstmid");
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m1_if.write_req != '0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("rstmid_wr_seen", 64'(found), 64'(1));
        #2 rst = 1'b1;
        #1;
        check_eq("rstmid_wr_drop",   64'(m1_if.write_req), 64'(0));
        check_eq("rstmid_rsp_valid", 64'(rsp_valid),       64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rstmid_req_ready", 64'(req_ready), 64'(1));
        for (int i = 0; i < 4; i++) begin
            check_eq("rstmid_no_rsp", 64'(rsp_valid), 64'(0));
            @(negedge clk);
        end
        check_eq("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file_access_master
